// File: rtl/adc_sched_pkg.sv
// ============================================================================
// adc_sched_pkg : shared types and defaults for the ADC scan scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_sched_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      WAIT  = ST_WAIT
   } state_t;

   localparam int NUM_CH_DEF  = 4;
   localparam int CH_W_DEF    = 2;
   localparam int DATA_W_DEF  = 12;
   localparam int TIMEOUT_DEF = 255;
   localparam int TMO_W       = 16;

endpackage

`default_nettype wire

// File: rtl/adc_scan_scheduler_ch_next_find.sv
// ============================================================================
// ch_next_find : lowest-set-bit priority encoder over a channel mask
// Rev 1.0
// ============================================================================
`default_nettype none

module ch_next_find
   import adc_sched_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = CH_W_DEF
) (
   input  logic [NUM_CH-1:0] mask_i,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   // Scanning downward lets the lowest set bit be the last (winning) write.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = CH_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/adc_scan_scheduler.sv
// ============================================================================
// adc_scan_scheduler : paces SPI ADC conversions across enabled channels
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_scan_scheduler
   import adc_sched_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int CH_W    = CH_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              tick,
   output logic              spi_start,
   output logic [CH_W-1:0]   spi_ch,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_data,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [DATA_W-1:0] res_data,
   output logic              scan_done,
   output logic              timeout_err,
   output logic              overrun
);

   state_t              state_q, state_d;
   logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
   logic [NUM_CH-1:0]   scan_mask_q, scan_mask_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                spi_start_q, spi_start_d;
   logic [CH_W-1:0]     spi_ch_q, spi_ch_d;
   logic                res_valid_q, res_valid_d;
   logic [CH_W-1:0]     res_ch_q, res_ch_d;
   logic [DATA_W-1:0]   res_data_q, res_data_d;
   logic                scan_done_q, scan_done_d;
   logic                tmo_err_q, tmo_err_d;
   logic                overrun_q, overrun_d;

   logic [NUM_CH-1:0]   rem_mask;
   logic [NUM_CH-1:0]   enc_mask;
   logic [CH_W-1:0]     enc_idx;
   logic                enc_any;
   logic                tmo_hit;
   logic                conv_end;

   // One encoder serves both scan start (live mask) and advance (remaining bits).
   assign rem_mask = scan_mask_q & ~(NUM_CH'(1) << cur_ch_q);
   assign enc_mask = (state_q == IDLE) ? ch_mask : rem_mask;
   assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT));
   assign conv_end = spi_done || tmo_hit;

   ch_next_find #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_ch_next_find (
      .mask_i (enc_mask),
      .idx_o  (enc_idx),
      .any_o  (enc_any)
   );

   always_comb begin
      state_d     = state_q;
      cur_ch_d    = cur_ch_q;
      scan_mask_d = scan_mask_q;
      tmo_cnt_d   = tmo_cnt_q;
      spi_start_d = 1'b0;
      spi_ch_d    = spi_ch_q;
      res_valid_d = 1'b0;
      res_ch_d    = res_ch_q;
      res_data_d  = res_data_q;
      scan_done_d = 1'b0;
      tmo_err_d   = 1'b0;
      overrun_d   = tick && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (tick && enable && enc_any) begin
               state_d     = START;
               scan_mask_d = ch_mask;
               cur_ch_d    = enc_idx;
               spi_start_d = 1'b1;
               spi_ch_d    = enc_idx;
            end
         end
         START: begin
            tmo_cnt_d = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (conv_end) begin
               // spi_done takes priority over a coincident timeout.
               if (spi_done) begin
                  res_valid_d = 1'b1;
                  res_ch_d    = cur_ch_q;
                  res_data_d  = spi_data;
               end else begin
                  tmo_err_d = 1'b1;
               end
               scan_mask_d = rem_mask;
               if (enc_any && enable) begin
                  state_d     = START;
                  cur_ch_d    = enc_idx;
                  spi_start_d = 1'b1;
                  spi_ch_d    = enc_idx;
               end else begin
                  state_d     = IDLE;
                  scan_done_d = 1'b1;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_ch_q    <= '0;
         scan_mask_q <= '0;
         tmo_cnt_q   <= '0;
         spi_start_q <= 1'b0;
         spi_ch_q    <= '0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_data_q  <= '0;
         scan_done_q <= 1'b0;
         tmo_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         scan_mask_q <= scan_mask_d;
         tmo_cnt_q   <= tmo_cnt_d;
         spi_start_q <= spi_start_d;
         spi_ch_q    <= spi_ch_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_data_q  <= res_data_d;
         scan_done_q <= scan_done_d;
         tmo_err_q   <= tmo_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign spi_start   = spi_start_q;
   assign spi_ch      = spi_ch_q;
   assign res_valid   = res_valid_q;
   assign res_ch      = res_ch_q;
   assign res_data    = res_data_q;
   assign scan_done   = scan_done_q;
   assign timeout_err = tmo_err_q;
   assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_scheduler.sv
// ============================================================================
// tb_adc_scan_scheduler : scoreboard bench with a scan-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_scan_scheduler;

   localparam int NCH = 4;
   localparam int TMO = 20;

   localparam int EV_RES  = 0;
   localparam int EV_TMO  = 1;
   localparam int EV_DONE = 2;

   typedef struct {
      int kind;
      int ch;
      int data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  ch_mask;
   logic        tick;
   logic        spi_start;
   logic [1:0]  spi_ch;
   logic        spi_done;
   logic [11:0] spi_data;
   logic        res_valid;
   logic [1:0]  res_ch;
   logic [11:0] res_data;
   logic        scan_done;
   logic        timeout_err;
   logic        overrun;

   adc_scan_scheduler #(
      .NUM_CH  (NCH),
      .CH_W    (2),
      .DATA_W  (12),
      .TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .ch_mask     (ch_mask),
      .tick        (tick),
      .spi_start   (spi_start),
      .spi_ch      (spi_ch),
      .spi_done    (spi_done),
      .spi_data    (spi_data),
      .res_valid   (res_valid),
      .res_ch      (res_ch),
      .res_data    (res_data),
      .scan_done   (scan_done),
      .timeout_err (timeout_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t        evq[$];
   int         spiq[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_starts = 0;
   int         n_done   = 0;
   int         ovr_cnt  = 0;
   int         start_cyc[NCH];
   int         res_cyc  = 0;
   int         done_cyc = 0;
   int         tmo_cyc  = 0;
   int         tick_cyc = 0;
   int         lat      = 10;
   logic [3:0] mute     = 4'b0000;
   logic [11:0] salt    = 12'h100;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   // Scan-level model: latched mask visited lowest-first, optionally cut short.
   task automatic model_scan(input logic [3:0] m, input int limit);
      ev_t e;
      int  n;
      n = 0;
      for (int c = 0; c < NCH; c++) begin
         if (m[c] && n < limit) begin
            spiq.push_back(c);
            e.ch   = c;
            e.kind = mute[c] ? EV_TMO : EV_RES;
            e.data = mute[c] ? 0 : int'(12'(salt + 12'(c)));
            evq.push_back(e);
            n++;
         end
      end
      if (n > 0) begin
         e.kind = EV_DONE; e.ch = 0; e.data = 0;
         evq.push_back(e);
      end
   endtask

   task automatic take(input int kind, input int ch, input int data);
      ev_t e;
      n_checks++;
      if (evq.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: got event kind=%0d ch=%0d data=%0h, required no output", kind, ch, data);
      end else begin
         e = evq.pop_front();
         if (e.kind != kind || (kind == EV_RES && (e.ch != ch || e.data != data))) begin
            n_fail++;
            $display("FAIL scoreboard: got kind=%0d ch=%0d data=%0h, required kind=%0d ch=%0d data=%0h",
                     kind, ch, data, e.kind, e.ch, e.data);
         end
      end
   endtask

   // Output monitor: pops the scoreboard whenever the DUT strobes a result.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (res_valid) begin
               take(EV_RES, int'(res_ch), int'(res_data));
               res_cyc = cyc;
            end
            if (timeout_err) begin
               take(EV_TMO, -1, 0);
               tmo_cyc = cyc;
            end
            if (scan_done) begin
               take(EV_DONE, 0, 0);
               done_cyc = cyc;
               n_done++;
            end
            if (overrun) ovr_cnt++;
         end
      end
   end

   // SPI engine model: answers each request lat cycles later unless muted.
   initial begin
      int c;
      forever begin
         @(negedge clk);
         if (spi_start && !reset) begin
            c = int'(spi_ch);
            start_cyc[c] = cyc;
            n_starts++;
            n_checks++;
            if (spiq.size() == 0) begin
               n_fail++;
               $display("FAIL spi_req: got request ch=%0d, required none", c);
            end else if (spiq[0] != c) begin
               n_fail++;
               $display("FAIL spi_req: got ch=%0d, required ch=%0d", c, spiq[0]);
               void'(spiq.pop_front());
            end else begin
               void'(spiq.pop_front());
            end
            if (!mute[c]) begin
               repeat (lat) @(posedge clk);
               #1 spi_done = 1'b1;
               spi_data = 12'(salt + 12'(c));
               @(posedge clk);
               #1 spi_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_tick();
      @(posedge clk);
      #1 tick = 1'b1;
      tick_cyc = cyc;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   task automatic wait_start(input int ch);
      int i;
      for (i = 0; i < 600; i++) begin
         @(negedge clk);
         if (spi_start && (ch < 0 || int'(spi_ch) == ch)) break;
      end
      if (i == 600) chk("wait_start_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 3000 && (evq.size() != 0 || spiq.size() != 0); i++) @(negedge clk);
      chk("drain_evq", evq.size(), 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic out_zero(input string pfx);
      chk({pfx, "_spi_start"}, int'(spi_start), 0);
      chk({pfx, "_spi_ch"}, int'(spi_ch), 0);
      chk({pfx, "_res_valid"}, int'(res_valid), 0);
      chk({pfx, "_res_ch"}, int'(res_ch), 0);
      chk({pfx, "_res_data"}, int'(res_data), 0);
      chk({pfx, "_scan_done"}, int'(scan_done), 0);
      chk({pfx, "_timeout_err"}, int'(timeout_err), 0);
      chk({pfx, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      int t0, o0, s0, d0;
      logic [3:0] m;
      bit inj;

      reset = 1'b1; enable = 1'b0; ch_mask = '0; tick = 1'b0;
      spi_done = 1'b0; spi_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      out_zero("reset");
      @(posedge clk);
      #1 reset = 1'b0;

      // Full scan 1011 with an overrun tick during channel 1.
      enable = 1'b1; ch_mask = 4'b1011; salt = 12'h100; lat = 10; mute = 4'b0000;
      o0 = ovr_cnt; s0 = n_starts; d0 = n_done;
      model_scan(4'b1011, NCH);
      do_tick();
      t0 = tick_cyc;
      wait_start(1);
      do_tick();
      wait_drain();
      chk("full_first_start_cycle", start_cyc[0], t0 + 1);
      chk("full_done_with_last_res", done_cyc, res_cyc);
      chk("full_overrun_count", ovr_cnt - o0, 1);
      chk("full_requests", n_starts - s0, 3);
      chk("full_scan_done_count", n_done - d0, 1);

      // Empty mask, then enable low: neither starts a scan.
      o0 = ovr_cnt; s0 = n_starts; d0 = n_done;
      ch_mask = 4'b0000;
      do_tick();
      repeat (20) @(negedge clk);
      enable = 1'b0; ch_mask = 4'b0101;
      do_tick();
      repeat (20) @(negedge clk);
      chk("empty_requests", n_starts - s0, 0);
      chk("empty_scan_done", n_done - d0, 0);
      chk("empty_overrun", ovr_cnt - o0, 0);

      // Timeout on channel 2.
      enable = 1'b1; ch_mask = 4'b0110; salt = 12'h3C0; lat = 5; mute = 4'b0100;
      model_scan(4'b0110, NCH);
      do_tick();
      wait_drain();
      chk("timeout_cycle", tmo_cyc, start_cyc[2] + 1 + TMO + 1);
      mute = 4'b0000;

      // Mid-scan mask change and enable drop during channel 2.
      enable = 1'b1; ch_mask = 4'b1110; salt = 12'h7F0; lat = 10;
      s0 = n_starts;
      model_scan(4'b1110, 2);
      do_tick();
      wait_start(1);
      #1 ch_mask = 4'b0001;
      wait_start(2);
      @(posedge clk);
      #1 enable = 1'b0;
      wait_drain();
      chk("midscan_requests", n_starts - s0, 2);
      enable = 1'b1;

      // Reset in the middle of a WAIT; the late spi_done must be ignored.
      ch_mask = 4'b0011; salt = 12'h2A0; lat = 10;
      model_scan(4'b0011, NCH);
      do_tick();
      wait_start(0);
      repeat (3) @(posedge clk);
      #1 evq.delete();
      spiq.delete();
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      out_zero("midreset");
      repeat (20) @(posedge clk);
      ch_mask = 4'b0110; salt = 12'h555;
      model_scan(4'b0110, NCH);
      do_tick();
      t0 = tick_cyc;
      wait_drain();
      chk("restart_lowest_ch_cycle", start_cyc[1], t0 + 1);

      // Randomized scans with random latency, mutes, mask churn and overruns.
      for (int it = 0; it < 24; it++) begin
         m    = 4'($urandom_range(0, 15));
         lat  = $urandom_range(1, 15);
         salt = 12'($urandom);
         mute = 4'($urandom) & 4'($urandom) & 4'($urandom);
         inj  = (m != 4'b0000) && ($urandom_range(0, 1) == 1);
         o0 = ovr_cnt; s0 = n_starts;
         ch_mask = m; enable = 1'b1;
         model_scan(m, NCH);
         do_tick();
         ch_mask = 4'($urandom);
         if (inj) begin
            wait_start(-1);
            do_tick();
         end
         if (m == 4'b0000) repeat (10) @(negedge clk);
         wait_drain();
         chk("rand_overrun", ovr_cnt - o0, inj ? 1 : 0);
         chk("rand_requests", n_starts - s0, $countones(m));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
